// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction FIFO with flush
// Optional INST_QUEUE_BYPASS_EN: empty-queue pass-through of the fetch entry to decode.
module inst_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [ADDR_WIDTH-1:0]    in_pc,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [ADDR_WIDTH-1:0]    out_pc,
   output logic [DATA_WIDTH-1:0]    out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic [ENT_W-1:0] head;
   logic             empty, push, pop;

   assign empty    = (cnt == '0);
   assign in_ready = (cnt != FULL);
   assign count    = cnt;
   assign head     = mem[rd_ptr];
   // flush wins: nothing is stored or consumed in a flush cycle
   assign pop      = ~empty & out_ready & ~flush;

`ifdef INST_QUEUE_BYPASS_EN
   logic byp;
   assign byp       = empty & in_valid & ~flush;
   assign out_valid = ~empty | byp;
   // a bypassed entry taken by decode this cycle never occupies a slot
   assign push      = in_valid & in_ready & ~flush & ~(byp & out_ready);
   assign {out_pc, out_data} = byp   ? {in_pc, in_data} :
                               empty ? '0 : head;
`else
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready & ~flush;
   assign {out_pc, out_data} = empty ? '0 : head;
`endif

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {in_pc, in_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed scoreboard bench for inst_queue
module tb_inst_queue;
   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_data;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_data;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] sb [$];

   inst_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_data(out_data),
      .out_ready(out_ready), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [31:0] pc);
      return pc ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: drive, check against the scoreboard model, advance the model
   task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
      logic        e_rdy, e_vld, take, store;
      logic [63:0] e_head;
      in_valid  = v;
      in_pc     = pc;
      in_data   = data_of(pc);
      out_ready = rdy;
      flush     = fl;
      #1;
      e_rdy  = (sb.size() != 4);
      e_vld  = (sb.size() != 0);
      e_head = e_vld ? sb[0] : 64'h0;
      store  = v & e_rdy & ~fl;
`ifdef INST_QUEUE_BYPASS_EN
      if (sb.size() == 0 && v && !fl) begin
         e_vld  = 1'b1;
         e_head = {pc, data_of(pc)};
         if (rdy) store = 1'b0;
      end
`endif
      chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_vld});
      chk("count", {29'b0, count}, 32'(sb.size()));
      chk("out_pc", out_pc, e_head[63:32]);
      chk("out_data", out_data, e_head[31:0]);
      take = e_vld & rdy & ~fl;
      if (fl) sb.delete();
      else begin
         if (take && sb.size() != 0) void'(sb.pop_front());
         if (store) sb.push_back({pc, data_of(pc)});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_data = '0;
      #12;
      chk("rst_count", {29'b0, count}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // fill to full, fifth push refused
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
      cycle(1'b1, 32'h10, 1'b0, 1'b0);
      chk("full_count", {29'b0, count}, 32'd4);
      // push and pop while full, then drain
      cycle(1'b1, 32'h10, 1'b1, 1'b0);
      chk("full_pp_head", out_pc, 32'h4);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // pointer wrap with streaming push/pop
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // flush with three entries and a concurrent push
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      cycle(1'b1, 32'h40, 1'b0, 1'b1);
      chk("flush_count", {29'b0, count}, 32'd0);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // asynchronous reset mid-cycle with two entries
      for (int i = 0; i < 2; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_count", {29'b0, count}, 32'd0);
      sb.delete();
      #1 rst_n = 1'b1;
      @(negedge clk);

      // empty queue, push with decode ready
      cycle(1'b1, 32'h20, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
